// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bus bundle for mem_arbiter.
// The slave view belongs to the arbiter; the master view drives it.
interface mem_arbiter_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
);
   logic              a_req;
   logic              a_we;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_wdata;
   logic              a_gnt;
   logic              a_done;
   logic [DATA_W-1:0] a_rdata;

   logic              b_req;
   logic              b_we;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_wdata;
   logic              b_gnt;
   logic              b_done;
   logic [DATA_W-1:0] b_rdata;

   logic              busy;
   logic [ADDR_W-1:0] mem_address_bus;
   logic              mem_enable;
   logic              mem_read_write;
   logic [DATA_W-1:0] mem_data_bus_in;
   logic [DATA_W-1:0] mem_data_bus_out;

   modport slave (
      input  a_req, a_we, a_addr, a_wdata,
      output a_gnt, a_done, a_rdata,
      input  b_req, b_we, b_addr, b_wdata,
      output b_gnt, b_done, b_rdata,
      output busy,
      output mem_address_bus, mem_enable,
      output mem_read_write, mem_data_bus_in,
      input  mem_data_bus_out
   );

   modport master (
      output a_req, a_we, a_addr, a_wdata,
      input  a_gnt, a_done, a_rdata,
      output b_req, b_we, b_addr, b_wdata,
      input  b_gnt, b_done, b_rdata,
      input  busy,
      input  mem_address_bus, mem_enable,
      input  mem_read_write, mem_data_bus_in,
      output mem_data_bus_out
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter serialising A/B requests onto
// the single-port data memory; one access per three cycles.
module mem_arbiter #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input logic          clk,
   input logic          rst_n,
   mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      COMPLETE
   } state_t;

   state_t            state_q;
   logic              last_b_q;
   logic              sel_b_q;
   logic              we_q;
   logic              busy_q;
   logic              a_gnt_q, b_gnt_q;
   logic              a_done_q, b_done_q;
   logic [DATA_W-1:0] a_rdata_q, b_rdata_q;
   logic              mem_en_q;
   logic              mem_rw_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;

   logic              any_req;
   logic              sel_b_d;
   logic              we_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] wdata_d;

   // On a tie, the port not granted last wins.
   always_comb begin
      any_req = bus.a_req | bus.b_req;
      sel_b_d = bus.b_req & (~bus.a_req | ~last_b_q);
      we_d    = sel_b_d ? bus.b_we    : bus.a_we;
      addr_d  = sel_b_d ? bus.b_addr  : bus.a_addr;
      wdata_d = sel_b_d ? bus.b_wdata : bus.a_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_b_q    <= 1'b1;
         sel_b_q     <= 1'b0;
         we_q        <= 1'b0;
         busy_q      <= 1'b0;
         a_gnt_q     <= 1'b0;
         b_gnt_q     <= 1'b0;
         a_done_q    <= 1'b0;
         b_done_q    <= 1'b0;
         a_rdata_q   <= '0;
         b_rdata_q   <= '0;
         mem_en_q    <= 1'b0;
         mem_rw_q    <= 1'b1;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         a_gnt_q  <= 1'b0;
         b_gnt_q  <= 1'b0;
         a_done_q <= 1'b0;
         b_done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (any_req) begin
                  state_q     <= ACCESS;
                  busy_q      <= 1'b1;
                  sel_b_q     <= sel_b_d;
                  last_b_q    <= sel_b_d;
                  we_q        <= we_d;
                  a_gnt_q     <= ~sel_b_d;
                  b_gnt_q     <= sel_b_d;
                  mem_en_q    <= 1'b1;
                  mem_rw_q    <= ~we_d;
                  mem_addr_q  <= addr_d;
                  mem_wdata_q <= wdata_d;
               end
            end
            ACCESS: begin
               state_q  <= COMPLETE;
               mem_en_q <= 1'b0;
               mem_rw_q <= 1'b1;
            end
            COMPLETE: begin
               state_q  <= IDLE;
               busy_q   <= 1'b0;
               a_done_q <= ~sel_b_q;
               b_done_q <= sel_b_q;
               // Memory read register is valid during COMPLETE.
               if (!we_q && !sel_b_q) a_rdata_q <= bus.mem_data_bus_out;
               if (!we_q &&  sel_b_q) b_rdata_q <= bus.mem_data_bus_out;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.a_gnt           = a_gnt_q;
   assign bus.b_gnt           = b_gnt_q;
   assign bus.a_done          = a_done_q;
   assign bus.b_done          = b_done_q;
   assign bus.a_rdata         = a_rdata_q;
   assign bus.b_rdata         = b_rdata_q;
   assign bus.busy            = busy_q;
   assign bus.mem_enable      = mem_en_q;
   assign bus.mem_read_write  = mem_rw_q;
   assign bus.mem_address_bus = mem_addr_q;
   assign bus.mem_data_bus_in = mem_wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 16x8 memory
// that acts on the rising edge and exposes a read register.
module tb_mem_arbiter;
   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   logic [7:0] mem [16];
   logic [7:0] rd_q;

   mem_arbiter_if #(.ADDR_W(4), .DATA_W(8)) bus ();

   mem_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.mem_data_bus_out = rd_q;

   always @(posedge clk) begin
      if (bus.mem_enable) begin
         if (bus.mem_read_write) rd_q <= mem[bus.mem_address_bus];
         else mem[bus.mem_address_bus] <= bus.mem_data_bus_in;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Drives one request, drops req after gnt, waits for done.
   task automatic run_access(input bit pb, input bit we,
                             input logic [3:0] addr,
                             input logic [7:0] wd,
                             output int lat,
                             output logic [7:0] rd);
      bit got;
      got = 1'b0;
      lat = 99;
      rd  = 8'hxx;
      if (!pb) begin
         bus.a_req = 1'b1; bus.a_we = we;
         bus.a_addr = addr; bus.a_wdata = wd;
      end else begin
         bus.b_req = 1'b1; bus.b_we = we;
         bus.b_addr = addr; bus.b_wdata = wd;
      end
      for (int i = 1; i <= 10; i++) begin
         if (!got) begin
            tick();
            if (bus.a_gnt) bus.a_req = 1'b0;
            if (bus.b_gnt) bus.b_req = 1'b0;
            if (pb ? bus.b_done : bus.a_done) begin
               lat = i;
               rd  = pb ? bus.b_rdata : bus.a_rdata;
               got = 1'b1;
            end
         end
      end
      bus.a_req = 1'b0;
      bus.b_req = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks++;
      if ({bus.busy, bus.mem_enable, bus.mem_read_write,
           bus.a_gnt, bus.b_gnt, bus.a_done, bus.b_done}
          !== 7'b0010000) begin
         failures++;
         $display("FAIL reset_ctrl got %b exp 0010000",
            {bus.busy, bus.mem_enable, bus.mem_read_write,
             bus.a_gnt, bus.b_gnt, bus.a_done, bus.b_done});
      end
      checks++;
      if ({bus.mem_address_bus, bus.mem_data_bus_in} !== 12'h000) begin
         failures++;
         $display("FAIL reset_bus got %h exp 000",
            {bus.mem_address_bus, bus.mem_data_bus_in});
      end
      checks++;
      if ({bus.a_rdata, bus.b_rdata} !== 16'h0000) begin
         failures++;
         $display("FAIL reset_rdata got %h exp 0000",
            {bus.a_rdata, bus.b_rdata});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_single_write_read();
      int lat;
      logic [7:0] rd;
      bus.a_req = 1'b1; bus.a_we = 1'b1;
      bus.a_addr = 4'd3; bus.a_wdata = 8'h5A;
      tick();
      checks++;
      if ({bus.a_gnt, bus.b_gnt, bus.mem_enable, bus.mem_read_write,
           bus.busy, bus.mem_address_bus, bus.mem_data_bus_in}
          !== {5'b10101, 4'd3, 8'h5A}) begin
         failures++;
         $display("FAIL wr_access got %b_%h_%h exp 10101_3_5a",
            {bus.a_gnt, bus.b_gnt, bus.mem_enable,
             bus.mem_read_write, bus.busy},
            bus.mem_address_bus, bus.mem_data_bus_in);
      end
      bus.a_req = 1'b0; bus.a_addr = 4'd9; bus.a_wdata = 8'h00;
      tick();
      checks++;
      if ({bus.mem_enable, bus.mem_read_write, bus.a_done}
          !== 3'b010) begin
         failures++;
         $display("FAIL wr_complete got %b exp 010",
            {bus.mem_enable, bus.mem_read_write, bus.a_done});
      end
      tick();
      checks++;
      if ({bus.a_done, bus.b_done, bus.busy} !== 3'b100) begin
         failures++;
         $display("FAIL wr_done got %b exp 100",
            {bus.a_done, bus.b_done, bus.busy});
      end
      checks++;
      if (mem[3] !== 8'h5A || bus.a_rdata !== 8'h00) begin
         failures++;
         $display("FAIL wr_effect got mem=%h rdata=%h exp 5a/00",
            mem[3], bus.a_rdata);
      end
      run_access(1'b0, 1'b0, 4'd3, 8'h00, lat, rd);
      checks++;
      if (lat !== 3 || rd !== 8'h5A) begin
         failures++;
         $display("FAIL rd_back got lat=%0d rd=%h exp 3/5a", lat, rd);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 4'd3;
      bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 4'd15;
      tick();
      checks++;
      if ({bus.a_gnt, bus.b_gnt, bus.mem_address_bus}
          !== {2'b10, 4'd3}) begin
         failures++;
         $display("FAIL sim_first got %b_%h exp 10_3",
            {bus.a_gnt, bus.b_gnt}, bus.mem_address_bus);
      end
      bus.a_req = 1'b0;
      tick();
      tick();
      checks++;
      if ({bus.a_done, bus.b_gnt, bus.mem_enable, bus.a_rdata}
          !== {3'b100, 8'h5A}) begin
         failures++;
         $display("FAIL sim_a_done got %b_%h exp 100_5a",
            {bus.a_done, bus.b_gnt, bus.mem_enable}, bus.a_rdata);
      end
      tick();
      checks++;
      if ({bus.b_gnt, bus.a_gnt, bus.mem_enable, bus.mem_address_bus}
          !== {3'b101, 4'd15}) begin
         failures++;
         $display("FAIL sim_b_gnt got %b_%h exp 101_f",
            {bus.b_gnt, bus.a_gnt, bus.mem_enable},
            bus.mem_address_bus);
      end
      bus.b_req = 1'b0;
      tick();
      tick();
      checks++;
      if ({bus.b_done, bus.a_done, bus.b_rdata} !== {2'b10, 8'h2F}) begin
         failures++;
         $display("FAIL sim_b_done got %b_%h exp 10_2f",
            {bus.b_done, bus.a_done}, bus.b_rdata);
      end
   endtask

   task automatic test_contention();
      int ng, nen, both;
      logic [3:0] order;
      ng = 0; nen = 0; both = 0; order = 4'h0;
      bus.a_we = 1'b0; bus.b_we = 1'b0;
      bus.a_addr = 4'd1; bus.b_addr = 4'd2;
      bus.a_req = 1'b1; bus.b_req = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (bus.mem_enable) nen++;
         if ((bus.a_gnt && bus.b_gnt) || (bus.a_done && bus.b_done))
            both++;
         if (bus.a_gnt || bus.b_gnt) begin
            if (ng < 4) order[ng] = bus.b_gnt;
            ng++;
         end
         bus.a_req = ~bus.a_gnt;
         bus.b_req = ~bus.b_gnt;
      end
      bus.a_req = 1'b0;
      bus.b_req = 1'b0;
      checks++;
      if (ng !== 4 || order !== 4'b1010) begin
         failures++;
         $display("FAIL rr_order got n=%0d ord=%b exp 4/1010", ng, order);
      end
      checks++;
      if (nen !== 4 || both !== 0) begin
         failures++;
         $display("FAIL rr_enable got en=%0d both=%0d exp 4/0", nen, both);
      end
      checks++;
      if (bus.b_done !== 1'b1 || bus.b_rdata !== 8'h22) begin
         failures++;
         $display("FAIL rr_last got done=%b rd=%h exp 1/22",
            bus.b_done, bus.b_rdata);
      end
      tick();
   endtask

   task automatic test_input_change();
      bus.b_req = 1'b1; bus.b_we = 1'b1;
      bus.b_addr = 4'd7; bus.b_wdata = 8'h11;
      tick();
      checks++;
      if ({bus.b_gnt, bus.mem_address_bus} !== {1'b1, 4'd7}) begin
         failures++;
         $display("FAIL chg_gnt got %b_%h exp 1_7",
            bus.b_gnt, bus.mem_address_bus);
      end
      bus.b_req = 1'b0; bus.b_addr = 4'd0; bus.b_wdata = 8'hFF;
      tick();
      checks++;
      if ({bus.mem_address_bus, bus.mem_data_bus_in} !== 12'h711) begin
         failures++;
         $display("FAIL chg_hold got %h_%h exp 7_11",
            bus.mem_address_bus, bus.mem_data_bus_in);
      end
      tick();
      checks++;
      if (bus.b_done !== 1'b1 || mem[7] !== 8'h11 || mem[0] !== 8'h20)
      begin
         failures++;
         $display("FAIL chg_mem got done=%b m7=%h m0=%h exp 1/11/20",
            bus.b_done, mem[7], mem[0]);
      end
   endtask

   task automatic test_reset_mid_access();
      int lat;
      logic [7:0] rd;
      bit seen;
      bus.a_req = 1'b1; bus.a_we = 1'b1;
      bus.a_addr = 4'd2; bus.a_wdata = 8'h99;
      tick();
      checks++;
      if ({bus.a_gnt, bus.mem_enable} !== 2'b11) begin
         failures++;
         $display("FAIL mid_gnt got %b exp 11",
            {bus.a_gnt, bus.mem_enable});
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.a_gnt, bus.mem_enable, bus.mem_read_write, bus.busy,
           bus.mem_address_bus, bus.mem_data_bus_in}
          !== {4'b0010, 4'd0, 8'h00}) begin
         failures++;
         $display("FAIL mid_async got %b_%h_%h exp 0010_0_00",
            {bus.a_gnt, bus.mem_enable, bus.mem_read_write, bus.busy},
            bus.mem_address_bus, bus.mem_data_bus_in);
      end
      bus.a_req = 1'b0;
      seen = 1'b0;
      tick();
      if (bus.a_done) seen = 1'b1;
      tick();
      if (bus.a_done) seen = 1'b1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (bus.a_done) seen = 1'b1;
      end
      checks++;
      if (mem[2] !== 8'h22 || seen !== 1'b0) begin
         failures++;
         $display("FAIL mid_lost got m2=%h done=%b exp 22/0",
            mem[2], seen);
      end
      run_access(1'b0, 1'b0, 4'd2, 8'h00, lat, rd);
      checks++;
      if (lat !== 3 || rd !== 8'h22) begin
         failures++;
         $display("FAIL mid_next got lat=%0d rd=%h exp 3/22", lat, rd);
      end
   endtask

   task automatic test_extremes();
      int lat;
      logic [7:0] rd;
      run_access(1'b0, 1'b1, 4'd15, 8'hFF, lat, rd);
      checks++;
      if (lat !== 3 || mem[15] !== 8'hFF) begin
         failures++;
         $display("FAIL ext_wr15 got lat=%0d m=%h exp 3/ff",
            lat, mem[15]);
      end
      run_access(1'b1, 1'b1, 4'd0, 8'h00, lat, rd);
      checks++;
      if (lat !== 3 || mem[0] !== 8'h00) begin
         failures++;
         $display("FAIL ext_wr0 got lat=%0d m=%h exp 3/00", lat, mem[0]);
      end
      run_access(1'b0, 1'b0, 4'd15, 8'h00, lat, rd);
      checks++;
      if (lat !== 3 || rd !== 8'hFF) begin
         failures++;
         $display("FAIL ext_rd15 got lat=%0d rd=%h exp 3/ff", lat, rd);
      end
      run_access(1'b1, 1'b0, 4'd0, 8'h00, lat, rd);
      checks++;
      if (lat !== 3 || rd !== 8'h00) begin
         failures++;
         $display("FAIL ext_rd0 got lat=%0d rd=%h exp 3/00", lat, rd);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rd_q     = 8'h00;
      for (int i = 0; i < 16; i++) mem[i] = 8'h20 + 8'(i);
      bus.a_req = 1'b0; bus.a_we = 1'b0;
      bus.a_addr = '0;  bus.a_wdata = '0;
      bus.b_req = 1'b0; bus.b_we = 1'b0;
      bus.b_addr = '0;  bus.b_wdata = '0;
      test_reset();
      test_single_write_read();
      test_simultaneous();
      test_contention();
      test_input_change();
      test_reset_mid_access();
      test_extremes();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
